// File: rtl/register_file_pkg.sv
// Shared definitions for the multi-port register file: clear-FSM states and
// packed-port slicing helper.
package register_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Bit offset of port `port` inside a packed bus of `width`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/register_file_clear_fsm.sv
// Clear sequencer: walks every entry after reset or on request and reports
// when the array is usable.
//
//  state    | meaning
//  ---------+-----------------------------------------------------
//  ST_CLEAR | zeroing entry[cnt_q] each clock, user writes dropped
//  ST_READY | array valid, user writes accepted, i_clear sampled
module register_file_clear_fsm
  import register_file_pkg::*;
#(
  parameter int NB_ADDR   = 5,
  parameter int RAM_DEPTH = 2 ** NB_ADDR
) (
  input  logic               i_clock,
  input  logic               i_reset_n,
  input  logic               i_clear,
  output logic               o_ready,
  output logic               o_clr_we,
  output logic [NB_ADDR-1:0] o_clr_addr
);

  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(RAM_DEPTH - 1);

  clr_state_e         state_q, state_d;
  logic [NB_ADDR-1:0] cnt_q, cnt_d;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    o_ready    = 1'b0;
    o_clr_we   = 1'b0;
    o_clr_addr = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        o_clr_we = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + NB_ADDR'(1);
        end
      end
      ST_READY: begin
        o_ready = 1'b1;
        if (i_clear) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: N combinational read ports, two prioritised write
// ports, optional bypass and hardwired-zero entry 0, with a sequential clear.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int NB_ADDR   = 5,
  parameter int NB_DATA   = 32,
  parameter int RAM_DEPTH = 2 ** NB_ADDR,
  parameter int N_READ    = 2,
  parameter int BYPASS    = 1,
  parameter int ZERO_REG  = 1
) (
  input  logic                      i_clock,
  input  logic                      i_reset_n,
  input  logic                      i_clear,
  input  logic                      i_we_0,
  input  logic                      i_we_1,
  input  logic [NB_ADDR-1:0]        i_write_addr_0,
  input  logic [NB_ADDR-1:0]        i_write_addr_1,
  input  logic [NB_DATA-1:0]        i_data_0,
  input  logic [NB_DATA-1:0]        i_data_1,
  input  logic [N_READ*NB_ADDR-1:0] i_read_addr,
  output logic [N_READ*NB_DATA-1:0] o_data,
  output logic                      o_ready
);

  localparam logic [NB_ADDR:0] DEPTH_W = (NB_ADDR + 1)'(RAM_DEPTH);

  logic [NB_DATA-1:0] mem [RAM_DEPTH];

  logic               clr_we;
  logic [NB_ADDR-1:0] clr_addr;

  register_file_clear_fsm #(
    .NB_ADDR  (NB_ADDR),
    .RAM_DEPTH(RAM_DEPTH)
  ) u_clear_fsm (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .o_ready   (o_ready),
    .o_clr_we  (clr_we),
    .o_clr_addr(clr_addr)
  );

  // Addresses that map to a real, writable/readable entry.
  function automatic logic addr_ok(input logic [NB_ADDR-1:0] a);
    return ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic               wr0_en, wr1_en;
  logic [NB_ADDR-1:0] wr0_addr;
  logic [NB_DATA-1:0] wr0_data;

  // The clear engine borrows write port 0; port 1 is idle while clearing.
  assign wr0_en   = clr_we | (i_we_0 & addr_ok(i_write_addr_0));
  assign wr0_addr = clr_we ? clr_addr : i_write_addr_0;
  assign wr0_data = clr_we ? '0 : i_data_0;
  assign wr1_en   = ~clr_we & i_we_1 & addr_ok(i_write_addr_1);

  // Port 1 is written last so it wins on an address collision.
  always_ff @(posedge i_clock) begin
    if (wr0_en) mem[wr0_addr] <= wr0_data;
    if (wr1_en) mem[i_write_addr_1] <= i_data_1;
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [NB_ADDR-1:0] ra;
    logic [NB_DATA-1:0] rd;

    assign ra = i_read_addr[port_lsb(k, NB_ADDR) +: NB_ADDR];

    always_comb begin
      rd = '0;
      if (o_ready && addr_ok(ra)) begin
        if ((BYPASS != 0) && i_we_1 && (i_write_addr_1 == ra))      rd = i_data_1;
        else if ((BYPASS != 0) && i_we_0 && (i_write_addr_0 == ra)) rd = i_data_0;
        else                                                         rd = mem[ra];
      end
    end

    assign o_data[port_lsb(k, NB_DATA) +: NB_DATA] = rd;
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: two instances (bypass+zero-reg, full depth) and
// (no bypass, no zero-reg, 24 entries) driven in lockstep against a reference model.
module tb_register_file_mp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [9:0]  ra = '0;
  logic [63:0] rd_a, rd_b;
  logic        rdy_a, rdy_b;

  always #5 clk = ~clk;

  register_file_mp #(
    .NB_ADDR(5), .NB_DATA(32), .RAM_DEPTH(32), .N_READ(2), .BYPASS(1), .ZERO_REG(1)
  ) dut_a (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_we_0(we0), .i_we_1(we1),
    .i_write_addr_0(wa0), .i_write_addr_1(wa1),
    .i_data_0(wd0), .i_data_1(wd1),
    .i_read_addr(ra), .o_data(rd_a), .o_ready(rdy_a)
  );

  register_file_mp #(
    .NB_ADDR(5), .NB_DATA(32), .RAM_DEPTH(24), .N_READ(2), .BYPASS(0), .ZERO_REG(0)
  ) dut_b (
    .i_clock(clk), .i_reset_n(rst_n), .i_clear(clr),
    .i_we_0(we0), .i_we_1(we1),
    .i_write_addr_0(wa0), .i_write_addr_1(wa1),
    .i_data_0(wd0), .i_data_1(wd1),
    .i_read_addr(ra), .o_data(rd_b), .o_ready(rdy_b)
  );

  // Reference model: per instance, contents plus "cycles of clearing left".
  logic [31:0] mmem  [2][32];
  int          busy  [2];
  bit          mrdy  [2];
  int          depth [2] = '{32, 24};
  bit          byp   [2] = '{1'b1, 1'b0};
  bit          zr    [2] = '{1'b1, 1'b0};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit wr_ok(input int m, input logic [4:0] a);
    return (int'(a) < depth[m]) && !(zr[m] && a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input int m, input logic [4:0] a);
    if (!mrdy[m] || !wr_ok(m, a)) return 32'd0;
    if (byp[m]) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
    return mmem[m][a];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mrdy[m] = 1'b0;
      busy[m] = depth[m];
      for (int i = 0; i < 32; i++) mmem[m][i] = '0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (!mrdy[m]) begin
        busy[m]--;
        if (busy[m] == 0) mrdy[m] = 1'b1;
      end else begin
        if (we0 && wr_ok(m, wa0)) mmem[m][wa0] = wd0;
        if (we1 && wr_ok(m, wa1)) mmem[m][wa1] = wd1;
        if (clr) begin
          for (int i = 0; i < 32; i++) mmem[m][i] = '0;
          busy[m] = depth[m];
          mrdy[m] = 1'b0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] rd [2];
    rd[0] = rd_a;
    rd[1] = rd_b;
    chk("ready_a", {31'd0, rdy_a}, {31'd0, mrdy[0]});
    chk("ready_b", {31'd0, rdy_b}, {31'd0, mrdy[1]});
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < 2; p++)
        chk($sformatf("rd_%s_p%0d_addr%0d", (m == 0) ? "a" : "b", p, ra[p*5 +: 5]),
            rd[m][p*32 +: 32], exp_rd(m, ra[p*5 +: 5]));
  endtask

  task automatic drive(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic c, input logic [9:0] r);
    we0 = w0; wa0 = a0; wd0 = d0;
    we1 = w1; wa1 = a1; wd1 = d1;
    clr = c;  ra  = r;
  endtask

  // Check at the falling edge, advance one rising edge, update the model.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_cycle(input bit allow_clear);
    logic [4:0] a0, a1;
    a0 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    a1 = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
    drive(1'($urandom), a0, $urandom, 1'($urandom), a1, $urandom,
          allow_clear && ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 1) == 0) ? {a1, a0} : 10'($urandom));
    tick();
  endtask

  // Counts cycles until instance A reports ready; user writes are offered
  // during the first 20 cycles, while both instances are still clearing.
  task automatic clear_window(input string tag);
    int n = 0;
    while (!rdy_a && n < 40) begin
      drive(n < 20, 5'd3, $urandom, n < 20, 5'($urandom), $urandom, 1'b0, {5'd3, 5'd3});
      #1;
      chk({tag, "_rd_zero"}, rd_a[31:0], 32'd0);
      tick();
      n++;
    end
    chk({tag, "_len"}, 32'(n), 32'd32);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_a", {31'd0, rdy_a}, 32'd0);
    chk("reset_data_a", rd_a[31:0], 32'd0);
    chk("reset_data_b", rd_b[63:32], 32'd0);
    rst_n = 1'b1;

    clear_window("init_clear");

    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, {5'(31 - i), 5'(i)});
      #1;
      chk("zero_after_clear", rd_a[31:0], 32'd0);
      tick();
    end

    drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, {5'd5, 5'd0});
    #1;
    chk("bypass_same_cycle_a", rd_a[63:32], 32'hDEADBEEF);
    chk("nobypass_same_cycle_b", rd_b[63:32], 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, {5'd5, 5'd5});
    #1;
    chk("write_next_cycle_a", rd_a[63:32], 32'hDEADBEEF);
    chk("write_next_cycle_b", rd_b[63:32], 32'hDEADBEEF);
    tick();

    drive(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, {5'd7, 5'd7});
    #1;
    chk("collide_bypass_a", rd_a[31:0], 32'h22);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, {5'd7, 5'd7});
    #1;
    chk("collide_stored_a", rd_a[63:32], 32'h22);
    chk("collide_stored_b", rd_b[31:0], 32'h22);
    tick();

    drive(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, 0, {5'd0, 5'd0});
    #1;
    chk("zero_reg_same_p0", rd_a[31:0], 32'd0);
    chk("zero_reg_same_p1", rd_a[63:32], 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, {5'd0, 5'd0});
    #1;
    chk("zero_reg_next_p0", rd_a[31:0], 32'd0);
    chk("zero_reg_next_p1", rd_a[63:32], 32'd0);
    chk("no_zero_reg_b", rd_b[31:0], 32'hFFFFFFFF);
    tick();

    for (int i = 0; i < 300; i++) rand_cycle(1'b1);
    for (int i = 0; i < 40 && !(rdy_a && rdy_b); i++) rand_cycle(1'b0);
    chk("ready_after_random", {30'd0, rdy_a, rdy_b}, 32'd3);

    drive(1, 5'd3, 32'hA5, 0, 0, 0, 0, {5'd3, 5'd3});
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, {5'd3, 5'd3});
    #1;
    chk("fill_addr3_a", rd_a[31:0], 32'hA5);
    tick();
    clear_window("req_clear");
    drive(0, 0, 0, 0, 0, 0, 0, {5'd3, 5'd3});
    #1;
    chk("addr3_cleared_a", rd_a[31:0], 32'd0);
    chk("addr3_cleared_b", rd_b[63:32], 32'd0);
    tick();

    for (int i = 0; i < 40; i++) rand_cycle(1'b0);

    drive(0, 0, 0, 0, 0, 0, 1, 10'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 10'($urandom));
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midclear_reset_ready", {31'd0, rdy_a}, 32'd0);
    model_reset();
    drive(1, 5'd9, 32'h1234, 0, 0, 0, 0, 10'd0);
    tick();
    rst_n = 1'b1;
    clear_window("restart_clear");

    for (int i = 0; i < 60; i++) rand_cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port register file: the next generation of the datapath register file. It adds:
- N combinational read ports.
- Two write ports with fixed priority.
- Optional write-to-read bypass.
- An optional hardwired-zero register 0.
- A sequential clear engine that zeroes every entry after reset or on request.

It sits between the decode stage (read ports) and writeback (write ports) of the pipelined CPU.

## Interface
- NB_ADDR, 5, address width
- NB_DATA, 32, data width
- RAM_DEPTH, 2**NB_ADDR, number of entries (≤ 2**NB_ADDR)
- N_READ, 2, number of read ports (1..4)
- BYPASS, 1, 1 = a read of an address written this cycle returns the write data
- ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes
- i_clock  in  1  single clock, rising edge
- i_reset_n  in  1  asynchronous, active-low reset
- i_clear  in  1  request full clear (pulse, sampled in READY)
- i_we_0 / i_we_1  in  1  write enables; port 1 has priority
- i_write_addr_0 / i_write_addr_1  in  NB_ADDR  write addresses
- i_data_0 / i_data_1  in  NB_DATA  write data
- i_read_addr  in  N_READ*NB_ADDR  packed read addresses; port k uses bits [k*NB_ADDR +: NB_ADDR]
- o_data  out  N_READ*NB_DATA  packed read data, same packing
- o_ready  out  1  high when the array is cleared and accepts writes

## Operation
- Clear FSM has two states: CLEAR and READY.
  - Reset assertion forces CLEAR asynchronously and sets the clear counter to 0.
  - In CLEAR, each clock writes 0 to entry[counter] and increments the counter.
  - When counter == RAM_DEPTH-1 is written, the FSM goes to READY.
  - In READY, i_clear=1 causes a transition to CLEAR with counter=0 on the next edge.
  - i_clear is ignored while in CLEAR.
- Writes in READY:
  - Each enabled port writes its entry on the rising edge.
  - Both ports targeting the same address: port 1 data is stored.
  - A write to address 0 is discarded when ZERO_REG=1.
  - A write to an address ≥ RAM_DEPTH is discarded.
- Writes in CLEAR are dropped silently; no buffering.
- Reads (combinational):
  - In CLEAR, all o_data ports read 0.
  - Address 0 with ZERO_REG=1 reads 0.
  - An address ≥ RAM_DEPTH reads 0.
  - If BYPASS=1 in READY and the address matches an enabled write this cycle, the port returns that write data, with port 1 taking priority. This does not apply to address 0 when ZERO_REG=1.
  - Otherwise the port returns the stored entry.
- Every read port is independent; any number of ports may read the same address.

## Timing
- Reset values:
  - o_ready = 0.
  - o_data = 0 on all ports.
  - FSM state = CLEAR, counter = 0.
  - Array contents are undefined until the clear completes.
- A clear takes exactly RAM_DEPTH cycles after reset release or after the i_clear edge. o_ready rises on the edge that writes the last entry.
- Read latency is 0 cycles.
  - BYPASS=0: write data is visible on the cycle after the write edge.
  - BYPASS=1: write data is visible in the same cycle.
- Reset asserted mid-clear restarts the clear from entry 0.
- Reset asserted mid-write means that write is lost.
- i_clear and a write in the same READY cycle: the write is performed, then the whole array is cleared.

## Structure
- Shared package register_file_pkg holds:
  - FSM state localparams ST_CLEAR=1'b0 and ST_READY=1'b1.
  - Helper function for packed-port slicing.
- Sub-module register_file_clear_fsm holds the state register, counter, o_ready, and the clear write strobe and address. The top level muxes the clear strobe over the write ports.
- The array is a plain reg memory with no reset, so it can map to distributed RAM.

## Test plan
- Reset release, RAM_DEPTH=32: o_ready=0 for 32 cycles, then 1; reading all 32 addresses returns 0.
- In READY, write 0xDEADBEEF to addr 5 via port 0 with BYPASS=1: read port 1 at addr 5 shows 0xDEADBEEF in the same cycle. With BYPASS=0 it shows 0 that cycle and 0xDEADBEEF the next.
- Both ports write addr 7 (port 0 = 0x11, port 1 = 0x22): next-cycle read of addr 7 returns 0x22.
- ZERO_REG=1, write 0xFFFFFFFF to addr 0: all read ports at addr 0 return 0 in the same and the next cycle.
- Fill addr 3 = 0xA5, pulse i_clear: o_ready=0 for 32 cycles; writes during that window are dropped; afterwards addr 3 reads 0.
- Assert i_reset_n=0 at clear counter 10 and release: o_ready stays 0 for a further full 32 cycles.
